// File: rtl/mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl
//
// Sequential unsigned WIDTH x WIDTH multiplier. One 2-bit x 2-bit multiplier
// cell is reused for every pair of 2-bit digits of the operands. Each partial
// product is shifted into place and added into a 2*WIDTH-bit accumulator.
// An operation takes D*D cycles in RUN, where D = WIDTH/2.
//
// Optional feature, enabled by defining MULT_SEQ_ZERO_BYPASS_EN:
//   an operand pair where a == 0 or b == 0 skips RUN. The result 0 is
//   presented one cycle after accept.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand pair on a/b is valid
//   in_ready   controller is IDLE and can accept operands (low during rst)
//   a, b       WIDTH-bit unsigned operands, captured on accept
//   out_valid  p holds a completed product (registered)
//   out_ready  consumer accepts p; only looked at while out_valid is high
//   p          2*WIDTH-bit product register; holds its value until the next
//              operation completes
//   busy       high whenever the controller is not IDLE
// -----------------------------------------------------------------------------

// 2-bit x 2-bit unsigned multiplier cell. It is shared by all digit steps.
module mult_2_bit (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [3:0] p_o
);
    assign p_o = {2'b00, a_i} * {2'b00, b_i};
endmodule

module mult_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);
    localparam int D  = WIDTH / 2;
    localparam int CW = (D > 1) ? $clog2(D) : 1;
    localparam int PW = 2 * WIDTH;
    // The largest shift is 2*(i+j) = 4*(D-1). CW+2 bits hold it.
    localparam int SW = CW + 2;
    localparam logic [CW-1:0] LAST = CW'(D - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    p_q;
    logic             out_valid_q;
    logic [CW-1:0]    i_q;
    logic [CW-1:0]    j_q;

    // ------------------------------------------------------------------
    // Split the captured operands into 2-bit digits.
    // ------------------------------------------------------------------
    logic [1:0] a_dig [D];
    logic [1:0] b_dig [D];

    for (genvar gi = 0; gi < D; gi++) begin : g_dig
        assign a_dig[gi] = a_q[2*gi +: 2];
        assign b_dig[gi] = b_q[2*gi +: 2];
    end

    logic [1:0] cell_a;
    logic [1:0] cell_b;
    logic [3:0] pp;

    assign cell_a = a_dig[i_q];
    assign cell_b = b_dig[j_q];

    mult_2_bit u_cell (
        .a_i (cell_a),
        .b_i (cell_b),
        .p_o (pp)
    );

    // Zero-extend the partial product before shifting it into position.
    logic [SW-1:0] shamt;
    logic [PW-1:0] pp_shift;
    logic [PW-1:0] acc_d;
    logic          last_step;

    assign shamt     = {1'b0, i_q, 1'b0} + {1'b0, j_q, 1'b0};
    assign pp_shift  = PW'(pp) << shamt;
    assign acc_d     = acc_q + pp_shift;
    assign last_step = (i_q == LAST) && (j_q == LAST);

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
            i_q         <= '0;
            j_q         <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // in_ready is high in IDLE whenever rst is low, so
                    // in_valid alone qualifies the accept here.
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        acc_q <= '0;
                        i_q   <= '0;
                        j_q   <= '0;
`ifdef MULT_SEQ_ZERO_BYPASS_EN
                        // A zero operand makes the product zero. Skip RUN
                        // and present the result right away.
                        if ((a == '0) || (b == '0)) begin
                            state_q     <= S_DONE;
                            p_q         <= '0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
`else
                        state_q <= S_RUN;
`endif
                    end
                end

                S_RUN: begin
                    acc_q <= acc_d;
                    // j is the inner digit loop. i advances when j wraps.
                    if (j_q == LAST) begin
                        j_q <= '0;
                        i_q <= (i_q == LAST) ? '0 : i_q + CW'(1);
                    end else begin
                        j_q <= j_q + CW'(1);
                    end
                    // Load the final sum into p when DONE is entered.
                    // This keeps p unchanged during every RUN step.
                    if (last_step) begin
                        state_q     <= S_DONE;
                        p_q         <= acc_d;
                        out_valid_q <= 1'b1;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // in_ready and busy are decoded from the state register. in_ready is
    // also masked by rst, so no accept can coincide with a reset edge.
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign p         = p_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for mult_seq_ctrl. Two instances are used: WIDTH=8 and WIDTH=2.
// The stimulus side pushes the expected product and latency into a queue on
// accept. A monitor per instance pops that queue when out_valid rises and
// compares the entry with the DUT output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mult_seq_ctrl;

`ifdef MULT_SEQ_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        longint prod;
        int     acc_edge;
        int     lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // WIDTH=8 instance
    logic        iv = 1'b0;
    logic        ir;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        ov;
    logic        ordy;
    logic [15:0] p;
    logic        busy;
    logic        rand_ro = 1'b0;
    logic        ro_rnd = 1'b0;
    logic        ro_man = 1'b1;

    assign ordy = rand_ro ? ro_rnd : ro_man;

    mult_seq_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
        .out_valid(ov), .out_ready(ordy), .p(p), .busy(busy)
    );

    // WIDTH=2 instance
    logic       iv2 = 1'b0;
    logic       ir2;
    logic [1:0] a2 = '0;
    logic [1:0] b2 = '0;
    logic       ov2;
    logic       ordy2 = 1'b1;
    logic [3:0] p2;
    logic       busy2;

    mult_seq_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .out_valid(ov2), .out_ready(ordy2), .p(p2), .busy(busy2)
    );

    exp_t sb8[$];
    exp_t sb2[$];
    int   tests = 0;
    int   fails = 0;
    int   last_hs = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat8(input logic [7:0] x, input logic [7:0] y);
        if (BYP && (x == 0 || y == 0)) return 1;
        return 16;
    endfunction

    // Random backpressure source.
    initial forever begin
        @(posedge clk); #1;
        ro_rnd = 1'($urandom_range(0, 1));
    end

    // Issue one operation on the WIDTH=8 instance. Call it at posedge+1.
    // It returns at posedge+1 just after the accept edge.
    task automatic issue8(input logic [7:0] x, input logic [7:0] y, output int acc_edge);
        exp_t e;
        bit   ok;
        iv = 1'b1; a = x; b = y;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (ir) begin ok = 1'b1; break; end
        end
        acc_edge = cyc + 1;
        if (!ok) begin
            chk("accept_timeout8", 0, 1);
        end else begin
            e.prod = longint'(x) * longint'(y);
            e.acc_edge = acc_edge;
            e.lat = lat8(x, y);
            sb8.push_back(e);
            $display("[TB] w8 accept %0d x %0d at edge %0d", x, y, acc_edge);
        end
        @(posedge clk); #1;
        // Change the inputs after accept. The operation in flight must
        // not depend on them.
        iv = 1'b0; a = 8'($urandom); b = 8'($urandom);
    endtask

    task automatic issue2(input logic [1:0] x, input logic [1:0] y);
        exp_t e;
        bit   ok;
        iv2 = 1'b1; a2 = x; b2 = y;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ir2) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            chk("accept_timeout2", 0, 1);
        end else begin
            e.prod = longint'(x) * longint'(y);
            e.acc_edge = cyc + 1;
            e.lat = 1;
            sb2.push_back(e);
        end
        @(posedge clk); #1;
        iv2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
    endtask

    task automatic drain8();
        int k;
        k = 0;
        while ((sb8.size() != 0 || ov) && k < 2000) begin @(negedge clk); k++; end
        chk("drain8_timeout", (sb8.size() == 0 && !ov), 1);
        @(posedge clk); #1;
    endtask

    // Monitor for the WIDTH=8 instance.
    initial begin : mon8
        exp_t   e;
        bit     vseen;
        bit     exp_rdy;
        longint cur;
        vseen = 0; exp_rdy = 0; cur = 0;
        forever begin
            @(negedge clk);
            if (rst) begin vseen = 0; exp_rdy = 0; continue; end
            if (exp_rdy) begin
                chk("in_ready_after_hs", ir, 1);
                chk("valid_drop_after_hs", ov, 0);
                chk("p_hold_after_hs", p, cur);
                exp_rdy = 0;
            end
            chk("busy_vs_ready", busy, !ir);
            if (ov) begin
                if (!vseen) begin
                    vseen = 1;
                    if (sb8.size() == 0) begin
                        chk("unexpected_out_valid", 1, 0);
                        cur = longint'(p);
                    end else begin
                        e = sb8.pop_front();
                        cur = e.prod;
                        $display("[TB] w8 result p=%0d expected %0d latency %0d", p, e.prod, cyc - e.acc_edge);
                        chk("product8", p, e.prod);
                        chk("latency8", cyc - e.acc_edge, e.lat);
                    end
                end else begin
                    chk("p_stable", p, cur);
                end
                if (ordy) begin
                    vseen = 0;
                    exp_rdy = 1;
                    last_hs = cyc + 1;
                end
            end
        end
    end

    // Monitor for the WIDTH=2 instance. out_ready is held high there.
    initial begin : mon2
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && ov2) begin
                if (sb2.size() == 0) begin
                    chk("unexpected_out_valid2", 1, 0);
                end else begin
                    e = sb2.pop_front();
                    $display("[TB] w2 result p=%0d expected %0d latency %0d", p2, e.prod, cyc - e.acc_edge);
                    chk("product2", p2, e.prod);
                    chk("latency2", cyc - e.acc_edge, e.lat);
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int e1;
        int k;
        logic [7:0] x, y;

        // Reset state
        repeat (3) @(negedge clk);
        chk("in_ready_in_reset", ir, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", ir, 1);
        chk("reset_busy", busy, 0);
        chk("reset_out_valid", ov, 0);
        chk("reset_p", p, 0);
        @(posedge clk); #1;

        // Directed: 255*255, then a zero operand
        ro_man = 1'b1;
        issue8(8'd255, 8'd255, e1);
        drain8();
        issue8(8'd0, 8'd77, e1);
        drain8();

        // Backpressure: hold 143 for 5 cycles while a new operand is waiting
        ro_man = 1'b0;
        issue8(8'd13, 8'd11, e1);
        k = 0;
        while (!ov && k < 100) begin @(negedge clk); k++; end
        chk("bp_out_valid_seen", ov, 1);
        @(posedge clk); #1;
        iv = 1'b1; a = 8'd2; b = 8'd2;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_no_accept", ir, 0);
        end
        @(posedge clk); #1;
        ro_man = 1'b1;
        issue8(8'd2, 8'd2, e1);
        chk("bp_accept_after_hs", e1, last_hs + 1);
        drain8();

        // Reset during RUN cycle 7
        issue8(8'd200, 8'd3, e1);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", ir, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb8.delete();
        @(negedge clk);
        chk("mid_rst_idle_ready", ir, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_p", p, 0);
        chk("mid_rst_out_valid", ov, 0);
        repeat (20) @(negedge clk);
        @(posedge clk); #1;
        issue8(8'd6, 8'd7, e1);
        drain8();

        // Back-to-back with out_ready held high
        issue8(8'd12, 8'd10, e1);
        issue8(8'd255, 8'd1, e1);
        chk("b2b_accept_after_hs", e1, last_hs + 1);
        drain8();

        // Random operands with random backpressure
        rand_ro = 1'b1;
        for (int n = 0; n < 30; n++) begin
            x = ($urandom_range(0, 6) == 0) ? 8'd0 : 8'($urandom);
            y = ($urandom_range(0, 6) == 0) ? 8'd0 : 8'($urandom);
            issue8(x, y, e1);
        end
        rand_ro = 1'b0;
        ro_man = 1'b1;
        drain8();

        // WIDTH=2: all 16 operand pairs
        for (int xa = 0; xa < 4; xa++) begin
            for (int yb = 0; yb < 4; yb++) begin
                issue2(2'(xa), 2'(yb));
            end
        end
        k = 0;
        while ((sb2.size() != 0 || ov2) && k < 200) begin @(negedge clk); k++; end
        chk("drain2_timeout", (sb2.size() == 0 && !ov2), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
